// File: rtl/calc_pkg.sv
// Shared types for the sequential BCD calculator: op codes, FSM states
// and the digit-count helper used to reject undersized DIGITS at elaboration.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    CONV,
    DONE
  } state_e;

  // Decimal digits needed for 2^(2*width)-1: floor(2*width*log10(2)) + 1.
  // 2^n is never a power of ten, so the truncated product is exact enough.
  function automatic int min_digits(input int width);
    return (2 * width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/seq_calc_bcd_if.sv
// Request/response bundle between the operand source and the calculator.
interface seq_calc_bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      x;
  logic [WIDTH-1:0]      y;
  logic [1:0]            op_sel;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  neg_led;
  logic                  carry_out;
  logic                  overflow;

  modport master (
    output start, x, y, op_sel,
    input  busy, done, result, neg_led, carry_out, overflow
  );

  modport slave (
    input  start, x, y, op_sel,
    output busy, done, result, neg_led, carry_out, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle, WIDTH_IN steps
// after load. done stays high for exactly the cycle after the last step.
module bin2bcd_seq #(
  parameter int WIDTH_IN = 16,
  parameter int DIGITS   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [WIDTH_IN-1:0] bin_in,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);
  localparam int CW = $clog2(WIDTH_IN + 1);

  logic [WIDTH_IN-1:0] sh;
  logic [4*DIGITS-1:0] bcd_r, adj;
  logic [CW-1:0]       cnt;
  logic                active;

  // Add 3 to every digit >= 5 ahead of the shift.
  always_comb begin
    adj = bcd_r;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_r[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
    end
  end

  // Load, then shift the binary MSB into the adjusted BCD register each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh     <= '0;
      bcd_r  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      sh     <= bin_in;
      bcd_r  <= '0;
      cnt    <= CW'(WIDTH_IN);
      active <= 1'b1;
    end else if (active) begin
      if (cnt != '0) begin
        {bcd_r, sh} <= {adj, sh} << 1;
        cnt         <= cnt - CW'(1);
      end else begin
        active <= 1'b0;
      end
    end
  end

  assign done = active && (cnt == '0);
  assign bcd  = bcd_r;

endmodule

// File: rtl/seq_calc_bcd.sv
// Multi-cycle calculator: add/sub/pass in one CALC cycle, shift-add multiply
// over WIDTH cycles, then sequential BCD conversion of the magnitude.
// Optional build macro: CALC_SIGNED_EN (two's-complement operands).
module seq_calc_bcd
  import calc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          reset,
  seq_calc_bcd_if.slave io
);
  localparam int MW  = 2 * WIDTH;
  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);

  if (WIDTH < 2 || DIGITS < min_digits(WIDTH)) begin : g_bad_cfg
    $error("seq_calc_bcd: WIDTH must be >= 2 and DIGITS large enough for 2*WIDTH bits");
  end

  state_e              state, state_nxt;
  op_e                 op_r;
  logic [WIDTH-1:0]    x_r, y_r, mp, mc_ld, mp_ld;
  logic [MW-1:0]       mc, acc, pp, mag_c;
  logic [CW-1:0]       cnt;
  logic [WIDTH:0]      sum, diff;
  logic                calc_last, load, conv_done;
  logic                neg_c, carry_c, ovf_c;
  logic                neg_p, carry_p, ovf_p;
  logic                neg_r, carry_r, ovf_r;
  logic [4*DIGITS-1:0] bcd, result_r;
  logic                accept;
`ifdef CALC_SIGNED_EN
  logic                msign_r;
  logic [WIDTH:0]      ssum, sdiff, smag;
  logic [WIDTH-1:0]    ax;
`endif

  assign accept    = (state == IDLE) && io.start;
  assign calc_last = (state == CALC) && ((op_r != OP_MUL) || (cnt == CW'(WIDTH - 1)));
  assign load      = calc_last;

  // Multiplier operands; signed builds multiply magnitudes and keep the sign aside.
  always_comb begin
    mc_ld = io.x;
    mp_ld = io.y;
`ifdef CALC_SIGNED_EN
    if (io.x[MSB]) mc_ld = -io.x;
    if (io.y[MSB]) mp_ld = -io.y;
`endif
  end

  // Result magnitude and flags from the registered operands.
  always_comb begin
    sum     = {1'b0, x_r} + {1'b0, y_r};
    diff    = {1'b0, x_r} - {1'b0, y_r};
    pp      = mp[0] ? mc : '0;
    mag_c   = '0;
    neg_c   = 1'b0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
`ifdef CALC_SIGNED_EN
    ssum  = {x_r[MSB], x_r} + {y_r[MSB], y_r};
    sdiff = {x_r[MSB], x_r} - {y_r[MSB], y_r};
    smag  = '0;
    ax    = x_r[MSB] ? -x_r : x_r;
`endif
    case (op_r)
      OP_ADD: begin
        carry_c = sum[WIDTH];
        ovf_c   = (x_r[MSB] == y_r[MSB]) && (sum[MSB] != x_r[MSB]);
`ifdef CALC_SIGNED_EN
        neg_c = ssum[WIDTH];
        smag  = ssum[WIDTH] ? -ssum : ssum;
        mag_c = MW'(smag);
`else
        mag_c = MW'(sum);
`endif
      end
      OP_SUB: begin
        carry_c = ~diff[WIDTH];
        ovf_c   = (x_r[MSB] != y_r[MSB]) && (diff[MSB] != x_r[MSB]);
`ifdef CALC_SIGNED_EN
        neg_c = sdiff[WIDTH];
        smag  = sdiff[WIDTH] ? -sdiff : sdiff;
        mag_c = MW'(smag);
`else
        neg_c = diff[WIDTH];
        mag_c = diff[WIDTH] ? MW'(y_r - x_r) : MW'(diff[WIDTH-1:0]);
`endif
      end
      OP_MUL: begin
        mag_c = acc + pp;
`ifdef CALC_SIGNED_EN
        neg_c = msign_r;
`endif
      end
      default: begin
`ifdef CALC_SIGNED_EN
        mag_c = MW'(ax);
        neg_c = x_r[MSB];
`else
        mag_c = MW'(x_r);
`endif
      end
    endcase
    if (mag_c == '0) neg_c = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.start) state_nxt = CALC;
      CALC:    if (calc_last) state_nxt = CONV;
      CONV:    if (conv_done) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, shift-add multiply and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r     <= OP_ADD;
      x_r      <= '0;
      y_r      <= '0;
      mc       <= '0;
      mp       <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_p    <= 1'b0;
      carry_p  <= 1'b0;
      ovf_p    <= 1'b0;
      result_r <= '0;
      neg_r    <= 1'b0;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
`ifdef CALC_SIGNED_EN
      msign_r  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_r <= op_e'(io.op_sel);
        x_r  <= io.x;
        y_r  <= io.y;
        mc   <= MW'(mc_ld);
        mp   <= mp_ld;
        acc  <= '0;
        cnt  <= '0;
`ifdef CALC_SIGNED_EN
        msign_r <= io.x[MSB] ^ io.y[MSB];
`endif
      end
      if (state == CALC) begin
        acc <= acc + pp;
        mc  <= mc << 1;
        mp  <= mp >> 1;
        cnt <= cnt + CW'(1);
      end
      if (calc_last) begin
        neg_p   <= neg_c;
        carry_p <= carry_c;
        ovf_p   <= ovf_c;
      end
      if (state == CONV && conv_done) begin
        result_r <= bcd;
        neg_r    <= neg_p;
        carry_r  <= carry_p;
        ovf_r    <= ovf_p;
      end
    end
  end

  bin2bcd_seq #(
    .WIDTH_IN (MW),
    .DIGITS   (DIGITS)
  ) u_bcd (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .bin_in (mag_c),
    .done   (conv_done),
    .bcd    (bcd)
  );

  assign io.busy      = (state != IDLE);
  assign io.done      = (state == DONE);
  assign io.result    = result_r;
  assign io.neg_led   = neg_r;
  assign io.carry_out = carry_r;
  assign io.overflow  = ovf_r;

endmodule

// File: tb/tb_seq_calc_bcd.sv
// Directed bench for seq_calc_bcd at WIDTH=8, DIGITS=5.
module tb_seq_calc_bcd;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total = 0;

  seq_calc_bcd_if #(.WIDTH(8), .DIGITS(5)) bus ();

  seq_calc_bcd #(.WIDTH(8), .DIGITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  // Outputs packed as {result, neg_led, carry_out, overflow}.
  function automatic logic [22:0] outs();
    return {bus.result, bus.neg_led, bus.carry_out, bus.overflow};
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns #1 after the
  // edge that raised done, with lat = edges from accept to done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] o, output int lat);
    bus.start = 1'b1; bus.x = a; bus.y = b; bus.op_sel = o;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.op_sel = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done, outs()} !== 25'd0)
      $display("FAIL reset_state got=%h exp=0", {bus.busy, bus.done, outs()});
    else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

`ifndef CALC_SIGNED_EN
  task automatic test_add();
    int lat;
    run_op(8'd200, 8'd100, ADD, lat);
    total++;
    if (lat !== 18) $display("FAIL add_latency got=%0d exp=18", lat); else pass_cnt++;
    total++;
    if (outs() !== {20'h00300, 1'b0, 1'b1, 1'b0})
      $display("FAIL add_200_100 got=%h exp=%h", outs(), {20'h00300, 3'b010});
    else pass_cnt++;
    @(posedge clk); #1;
    total++;
    if ({bus.done, bus.busy} !== 2'b00)
      $display("FAIL done_pulse got=%b exp=00", {bus.done, bus.busy});
    else pass_cnt++;
  endtask

  task automatic test_sub();
    int lat;
    run_op(8'd5, 8'd9, SUB, lat);
    total++;
    if (outs() !== {20'h00004, 1'b1, 1'b0, 1'b0})
      $display("FAIL sub_5_9 got=%h exp=%h", outs(), {20'h00004, 3'b100});
    else pass_cnt++;
    @(posedge clk); #1;
    run_op(8'd9, 8'd9, SUB, lat);
    total++;
    if (outs() !== {20'h00000, 1'b0, 1'b1, 1'b0} || lat !== 18)
      $display("FAIL sub_9_9 got=%h lat=%0d exp=%h lat=18", outs(), lat, {20'h0, 3'b010});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int lat;
    run_op(8'd255, 8'd255, MUL, lat);
    total++;
    if (lat !== 25) $display("FAIL mul_latency got=%0d exp=25", lat); else pass_cnt++;
    total++;
    if (outs() !== {20'h65025, 3'b000})
      $display("FAIL mul_255_255 got=%h exp=%h", outs(), {20'h65025, 3'b000});
    else pass_cnt++;
    @(posedge clk); #1;
    run_op(8'd0, 8'd77, MUL, lat);
    total++;
    if (outs() !== 23'd0) $display("FAIL mul_0_77 got=%h exp=0", outs()); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    int dones;
    bus.start = 1'b1; bus.x = 8'd100; bus.y = 8'd100; bus.op_sel = ADD;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    // A start while busy must be dropped.
    bus.start = 1'b1; bus.x = 8'd3; bus.y = 8'd3; bus.op_sel = MUL;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 6;
    while (!bus.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (outs() !== {20'h00200, 1'b0, 1'b0, 1'b1} || lat !== 18)
      $display("FAIL add_100_100 got=%h lat=%0d exp=%h lat=18", outs(), lat, {20'h00200, 3'b001});
    else pass_cnt++;
    // Start raised during DONE: ignored on that edge, accepted on the next.
    bus.start = 1'b1; bus.x = 8'd1; bus.y = 8'd2; bus.op_sel = ADD;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL start_in_done got=%b exp=0", bus.busy); else pass_cnt++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) $display("FAIL accept_after_done got=%b exp=1", bus.busy); else pass_cnt++;
    total++;
    if (outs() !== {20'h00200, 3'b001})
      $display("FAIL hold_at_accept got=%h exp=%h", outs(), {20'h00200, 3'b001});
    else pass_cnt++;
    lat = 0;
    while (!bus.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (outs() !== {20'h00003, 3'b000} || lat !== 18)
      $display("FAIL add_1_2 got=%h lat=%0d exp=%h lat=18", outs(), lat, {20'h00003, 3'b000});
    else pass_cnt++;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    total++;
    if (dones !== 0 || outs() !== {20'h00003, 3'b000})
      $display("FAIL no_second_done got=%0d dones out=%h exp=0 dones out=%h", dones, outs(), {20'h00003, 3'b000});
    else pass_cnt++;
  endtask
`else
  task automatic test_signed();
    int lat;
    run_op(8'hFD, 8'd7, MUL, lat);
    total++;
    if (outs() !== {20'h00021, 1'b1, 1'b0, 1'b0} || lat !== 25)
      $display("FAIL smul_m3_7 got=%h lat=%0d exp=%h lat=25", outs(), lat, {20'h00021, 3'b100});
    else pass_cnt++;
    @(posedge clk); #1;
    run_op(8'h80, 8'd1, SUB, lat);
    total++;
    if (outs() !== {20'h00129, 1'b1, 1'b1, 1'b1} || lat !== 18)
      $display("FAIL ssub_m128_1 got=%h lat=%0d exp=%h lat=18", outs(), lat, {20'h00129, 3'b111});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_reset_mid();
    int lat;
    int dones;
    bus.start = 1'b1; bus.x = 8'd255; bus.y = 8'd255; bus.op_sel = MUL;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.done, outs()} !== 25'd0)
      $display("FAIL reset_mid_conv got=%h exp=0", {bus.busy, bus.done, outs()});
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    total++;
    if (dones !== 0) $display("FAIL reset_no_done got=%0d exp=0", dones); else pass_cnt++;
    run_op(8'd1, 8'd2, ADD, lat);
    total++;
    if (outs() !== {20'h00003, 3'b000} || lat !== 18)
      $display("FAIL post_reset_add got=%h lat=%0d exp=%h lat=18", outs(), lat, {20'h00003, 3'b000});
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
`ifndef CALC_SIGNED_EN
    test_add();
    test_sub();
    test_mul();
    test_back_to_back();
`else
    test_signed();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/seq_calc_bcd.md
Name: seq_calc_bcd

Overview:
Parametrised, multi-cycle successor to the combinational 4-bit calculator. It captures two WIDTH-bit operands and an op code on a start handshake, then computes add, sub or mul. Multiply uses an iterative shift-add datapath. The result magnitude goes through a sequential double-dabble converter, and the block presents BCD digits plus sign and status flags with a done pulse. It sits between the operand switches/registers and the 7-segment display driver.

Parameters:
WIDTH, 8, operand width in bits (≥2)
DIGITS, 5, BCD output digits; must satisfy 10^DIGITS > 2^(2*WIDTH)-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; accepted only when busy=0
x  in  WIDTH  operand A
y  in  WIDTH  operand B
op_sel  in  2  00 add, 01 sub, 10 mul, 11 pass x
busy  out  1  high from accept edge until done cycle ends
done  out  1  one-cycle pulse; outputs valid from this cycle
result  out  4*DIGITS  BCD magnitude, digit 0 in [3:0]
neg_led  out  1  result negative
carry_out  out  1  add/sub carry (see rules)
overflow  out  1  two's-complement overflow of WIDTH-bit add/sub

Behaviour:
- Reset (async, any state): FSM→IDLE; busy, done, result, neg_led, carry_out, overflow all 0. Reset mid-operation discards the operation and produces no done.
- FSM IDLE→CALC on start&~busy. x, y, op_sel are registered on the accept edge; later input changes are ignored.
- CALC length C: 1 cycle for add/sub/pass, WIDTH cycles for mul (one partial product per cycle, LSB of y first).
- CALC→CONV: magnitude is loaded into a 2*WIDTH-bit register. CONV runs exactly 2*WIDTH cycles of shift/add-3.
- CONV→DONE: done=1 for one cycle, result/flags update on entry to DONE. Next edge DONE→IDLE, busy=0.
- Latency from accept edge to done high = C+2*WIDTH+1 edges. WIDTH=8: add/sub/pass 18, mul 25.
- start while busy is ignored, not queued. start in the DONE cycle is ignored. start in IDLE the cycle after DONE is accepted.
- Outputs hold their values until the next DONE. They do not clear at accept.
- Unsigned arithmetic:
  - add: mag = x+y (WIDTH+1 bits); carry_out = bit WIDTH; neg_led=0.
  - sub: if y>x then mag=y-x and neg_led=1, else mag=x-y; carry_out = (x>=y).
  - overflow (add/sub) = signed overflow of the WIDTH-bit result, informational only.
  - mul: mag = x*y (2*WIDTH bits); carry_out=0, overflow=0, neg_led=0.
  - pass: mag=x, all flags 0.
- Zero result is never negative: neg_led=0 whenever mag=0.

Optional Feature:
CALC_SIGNED_EN
- Defined: x, y are two's complement.
  - add/sub are computed at WIDTH+1 bits signed.
  - mul is computed as |x|*|y| with sign = x[MSB]^y[MSB].
  - pass is |x|.
  - neg_led = sign of the true result (0 if zero); result = |true result|. For WIDTH=8, -128*-128 = 16384 still fits.
  - carry_out and overflow behave as in unsigned mode.
- Undefined: unsigned behaviour above; no sign-extension logic is built.

Decomposition:
- Package calc_pkg:
  - op_sel encodings OP_ADD, OP_SUB, OP_MUL, OP_PASS;
  - FSM state enum IDLE/CALC/CONV/DONE;
  - function computing the minimum DIGITS for a width, used for an elaboration check.
- Sub-module bin2bcd_seq (WIDTH_IN=2*WIDTH, DIGITS): load/start in, done out, iterative double dabble. The top-level FSM waits on its done.

Test Plan:
- WIDTH=8, add x=200 y=100 → result=0x00300, carry_out=1, overflow=0, neg_led=0; done exactly 18 cycles after accept, single-cycle pulse.
- sub x=5 y=9 → result=0x00004, neg_led=1, carry_out=0; sub x=9 y=9 → result=0, neg_led=0, carry_out=1.
- mul x=255 y=255 → result=0x65025, flags 0, done at cycle 25; mul x=0 y=77 → 0x00000.
- add x=100 y=100 → result=0x00200, overflow=1, carry_out=0. Pulse start again while busy → no second done, outputs unchanged.
- Assert reset during CONV of 255*255 → all outputs 0 immediately, busy=0, no done. Next add 1+2 → 0x00003.
- With CALC_SIGNED_EN: mul x=0xFD y=7 → result=0x00021, neg_led=1; sub x=0x80 y=1 → result=0x00129, neg_led=1, overflow=1.
